// File: rtl/pe_seq_encoder_if.sv
// Handshake bundle for pe_seq_encoder: request side (req/in_valid/mode) and
// result side (out_idx/out_v/out_valid/out_ready).
interface pe_seq_encoder_if #(
  parameter int N = 8
);
  localparam int W = $clog2(N);

  logic [N-1:0] req;
  logic         in_valid;
  logic         in_ready;
  logic         mode;
  logic [W-1:0] out_idx;
  logic         out_v;
  logic         out_valid;
  logic         out_ready;

  // master: request source plus downstream consumer; slave: the encoder
  modport master (
    output req, in_valid, mode, out_ready,
    input  in_ready, out_idx, out_v, out_valid
  );
  modport slave (
    input  req, in_valid, mode, out_ready,
    output in_ready, out_idx, out_v, out_valid
  );
endinterface

// File: rtl/pe_seq_encoder.sv
// Registered N-to-log2(N) priority encoder behind a valid/ready handshake.
// Optional round-robin priority compiled in with macro PE_RR_EN.
module pe_seq_encoder #(
  parameter int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  pe_seq_encoder_if.slave bus
);

  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_idx_q,   out_idx_d;
  logic         out_v_q,     out_v_d;
  logic         in_ready;
  logic         capture;
  logic         any_req;
  logic [W-1:0] fix_idx;
  logic [W-1:0] win_idx;

  assign in_ready = !out_valid_q || bus.out_ready;
  assign capture  = bus.in_valid && in_ready;
  assign any_req  = |bus.req;

  // Fixed priority: ascending scan, so the highest set index is written last.
  always_comb begin
    fix_idx = '0;
    for (int i = 0; i < N; i++)
      if (bus.req[i]) fix_idx = W'(i);
  end

`ifdef PE_RR_EN
  logic [W-1:0] ptr_q, ptr_d;
  logic [W-1:0] hi_idx, lo_idx, rr_idx;
  logic         hi_hit;

  // Round-robin without a modulo: the lowest set bit above ptr wins,
  // otherwise wrap to the lowest set bit at or below ptr.
  always_comb begin
    hi_hit = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (bus.req[i]) begin
        if (W'(i) > ptr_q) begin
          hi_hit = 1'b1;
          hi_idx = W'(i);
        end else begin
          lo_idx = W'(i);
        end
      end
    end
    rr_idx  = hi_hit ? hi_idx : lo_idx;
    win_idx = bus.mode ? rr_idx : fix_idx;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (capture && bus.mode && any_req) ptr_d = rr_idx;
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= W'(N - 1);
    else     ptr_q <= ptr_d;
  end
`else
  logic unused_mode;
  assign unused_mode = bus.mode;
  assign win_idx     = fix_idx;
`endif

  // Accept-and-capture in one edge replaces the result; idx/v hold on drain.
  always_comb begin
    out_valid_d = out_valid_q;
    out_idx_d   = out_idx_q;
    out_v_d     = out_v_q;
    if (capture) begin
      out_valid_d = 1'b1;
      out_v_d     = any_req;
      out_idx_d   = any_req ? win_idx : '0;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_v_q     <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      out_v_q     <= out_v_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.out_v     = out_v_q;

endmodule

// File: tb/tb_pe_seq_encoder.sv
// Directed + randomized bench for pe_seq_encoder against a queue-free
// behavioural model of the encoder's priority and handshake rules.
module tb_pe_seq_encoder;
  localparam int N = 8;

  logic clk;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;

  // reference model state
  int   m_valid = 0;
  int   m_idx   = 0;
  int   m_v     = 0;
  int   m_ptr   = N - 1;

  pe_seq_encoder_if #(.N(N)) bus ();
  pe_seq_encoder #(.N(N)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_fixed(input logic [N-1:0] r);
    int w = 0;
    for (int i = 0; i < N; i++) if (r[i]) w = i;
    return w;
  endfunction

  function automatic int ref_rr(input logic [N-1:0] r, input int p);
    for (int k = 1; k <= N; k++) begin
      int j = (p + k) % N;
      if (r[j]) return j;
    end
    return 0;
  endfunction

  // Inputs are already set; check in_ready, advance model, clock, check outputs.
  task automatic cyc();
    int rdy, rr_on, win;
    #1;
    rdy = (m_valid == 0 || bus.out_ready) ? 1 : 0;
    chk("in_ready", bus.in_ready, rdy);
`ifdef PE_RR_EN
    rr_on = int'(bus.mode);
`else
    rr_on = 0;
`endif
    if (rst) begin
      m_valid = 0; m_idx = 0; m_v = 0; m_ptr = N - 1;
    end else if (bus.in_valid && rdy == 1) begin
      m_valid = 1;
      m_v     = (bus.req != 0) ? 1 : 0;
      win     = rr_on ? ref_rr(bus.req, m_ptr) : ref_fixed(bus.req);
      m_idx   = m_v ? win : 0;
      if (rr_on && m_v) m_ptr = win;
    end else if (m_valid && bus.out_ready) begin
      m_valid = 0;
    end
    @(posedge clk);
    @(negedge clk);
    chk("out_valid", bus.out_valid, m_valid);
    chk("out_idx",   bus.out_idx,   m_idx);
    chk("out_v",     bus.out_v,     m_v);
  endtask

  initial begin
    rst = 1'b1;
    bus.req = '0; bus.in_valid = 1'b0; bus.mode = 1'b0; bus.out_ready = 1'b1;
    @(negedge clk);
    cyc();
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_idx",   bus.out_idx,   0);
    chk("rst_v",     bus.out_v,     0);
    chk("rst_ready", bus.in_ready,  1);

    // basic fixed-priority capture
    rst = 1'b0; bus.in_valid = 1'b1; bus.req = 8'b0010_1100; cyc();
    chk("fix_2c_idx", bus.out_idx, 5);
    chk("fix_2c_v",   bus.out_v,   1);

    // zero vector is still a handshaked result
    bus.req = 8'h00; cyc();
    chk("zero_v",     bus.out_v,     0);
    chk("zero_valid", bus.out_valid, 1);
    bus.out_ready = 1'b0; bus.req = 8'h40; cyc();
    chk("zero_held_v", bus.out_v, 0);
    bus.out_ready = 1'b1; cyc();
    chk("after_zero_idx", bus.out_idx, 6);

    // backpressure
    bus.req = 8'h01; cyc();
    bus.out_ready = 1'b0; bus.req = 8'h80;
    for (int c = 0; c < 3; c++) begin
      cyc();
      chk("bp_ready", bus.in_ready, 0);
      chk("bp_idx",   bus.out_idx,  0);
    end
    bus.out_ready = 1'b1; cyc();
    chk("bp_release_idx", bus.out_idx, 7);
    bus.in_valid = 1'b0; cyc();
    chk("drain_valid", bus.out_valid, 0);
    chk("drain_idx",   bus.out_idx,   7);

`ifdef PE_RR_EN
    begin
      int exp_seq[4] = '{0, 2, 7, 0};
      rst = 1'b1; cyc(); rst = 1'b0;
      bus.mode = 1'b1; bus.in_valid = 1'b1; bus.req = 8'b1000_0101;
      for (int c = 0; c < 4; c++) begin
        cyc();
        chk("rr_seq", bus.out_idx, exp_seq[c]);
      end
      rst = 1'b1; cyc(); rst = 1'b0;
      cyc(); cyc();
      chk("rr_w2", bus.out_idx, 2);
      bus.req = 8'h00; cyc();
      bus.req = 8'b0000_0101; cyc();
      chk("rr_zero_keep_ptr", bus.out_idx, 0);
    end
`endif

    // reset while holding a result with a capture pending
    bus.mode = 1'b0; bus.in_valid = 1'b1; bus.req = 8'h55; bus.out_ready = 1'b0; cyc();
    rst = 1'b1; cyc();
    chk("midrst_valid", bus.out_valid, 0);
    chk("midrst_v",     bus.out_v,     0);
    chk("midrst_idx",   bus.out_idx,   0);
    rst = 1'b0; bus.mode = 1'b1; bus.req = 8'hFF; bus.out_ready = 1'b1; cyc();
`ifdef PE_RR_EN
    chk("midrst_rr_ff", bus.out_idx, 0);
`else
    chk("midrst_fix_ff", bus.out_idx, 7);
`endif

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      int sel = $urandom_range(0, 7);
      rst           = ($urandom_range(0, 49) == 0);
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      bus.mode      = $urandom_range(0, 1);
      if (sel == 0)      bus.req = '0;
      else if (sel < 3)  bus.req = N'(1) << $urandom_range(0, N - 1);
      else               bus.req = N'($urandom);
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
